// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and default width for serial_adder
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational one-bit full adder cell
module full_adder_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder around one full_adder_bit
// Optional subtract mode (sub port) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_sha;
  logic [WIDTH-1:0]   r_shb;
  logic [WIDTH-2:0]   r_shs;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_shs_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force carry-in high.
  assign w_b_load = sub ? ~B : B;
  assign w_c_load = sub ? 1'b1 : Cin;
`else
  assign w_b_load = B;
  assign w_c_load = Cin;
`endif

  full_adder_bit u_fa (
    .A    (r_sha[0]),
    .B    (r_shb[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // Full partial sum after this bit; the shift register keeps the upper WIDTH-1 bits.
  assign w_shs_next = {w_fa_sum, r_shs};

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_shs   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sha   <= A;
            r_shb   <= w_b_load;
            r_carry <= w_c_load;
            r_shs   <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
          r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
          r_shs   <= w_shs_next[WIDTH-1:1];
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_sum  <= w_shs_next;
            r_cout <= w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] last_sum;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation, watch it to completion, then check result and handshake.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic icin, input logic isub,
                        input logic [WIDTH-1:0] esum, input logic ecout, input bit poke);
    int nb;
    int nd;
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (poke && i == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end
      if (poke && i == 4) start = 1'b0;
      if (busy && done) check({tag, " busy_done_overlap"}, 1, 0);
      if (i == WIDTH - 1) check({tag, " sum_held"}, sum, last_sum);
      nb += int'(busy);
      nd += int'(done);
    end
    check({tag, " busy_cycles"}, nb, WIDTH);
    check({tag, " done_pulses"}, nd, 1);
    check({tag, " sum"}, sum, esum);
    check({tag, " cout"}, cout, ecout);
    last_sum = esum;
  endtask

  initial begin
    int nd;
    int first_done;
    int second_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    last_sum = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 8'h00);
    check("reset cout", cout, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle busy", busy, 0);
    end

    run_op("basic",     8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("wrap",      8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("carry_in",  8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("alt_bits",  8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("busy_poke", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);

    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst sum", sum, 8'h00);
    check("midrst cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("midrst no_done", nd, 0);
    last_sum = '0;
    run_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    nd = 0; first_done = -1; second_done = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) first_done = i; else second_done = i;
        nd++;
        if (nd == 2) break;
      end
    end
    start = 1'b0;
    check("stream done_count", nd, 2);
    check("stream period", second_done - first_done, WIDTH + 2);
    check("stream sum", sum, 8'h03);
    last_sum = 8'h03;
    repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_borrow",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op("sub_cin_ign",  8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op("sub0_add",     8'h05, 8'h07, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that feeds one single-bit full-adder cell LSB-first, one bit per clock, with a registered carry between bits. It sits directly upstream of the full-adder cell and drives its A/B/Cin inputs from operand shift registers. It collects Sum/Cout back into a result register. A start/busy/done handshake lets a controller or test bench launch one addition and wait for its result.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  launch request; sampled only in IDLE
- A  input  WIDTH  operand A; captured on the accepted start edge
- B  input  WIDTH  operand B; captured on the accepted start edge
- Cin  input  1  carry-in; captured on the accepted start edge
- sub  input  1  subtract select; present only when SERIAL_ADDER_SUB_EN is defined
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse when Sum/Cout become valid
- Sum  output  WIDTH  registered result; holds until the next completion
- Cout  output  1  registered final carry-out; holds until the next completion

## Operation
- FSM states: IDLE, RUN, DONE. Encoding: 2 bits.
- IDLE:
  - start=1 loads shA<=A, shB<=B, carry<=Cin and cnt<=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - The FA cell sees shA[0], shB[0] and carry.
  - Its sum bit shifts into the MSB of shS, and shS shifts right.
  - carry<=FA Cout; shA and shB shift right; cnt<=cnt+1.
  - At cnt==WIDTH-1, the FSM goes to DONE.
- DONE, for one cycle:
  - Sum<=shS and Cout<=carry (both loaded on the RUN->DONE edge).
  - done=1, then the FSM returns to IDLE.
- start is ignored in RUN and DONE. It is not queued.
- If start is held high continuously, a new operation is accepted on the first IDLE cycle after DONE.
- cnt width: $clog2(WIDTH). Arithmetic is modulo 2^WIDTH. Overflow is reported only through Cout.
- Sum and Cout never show partial results. They change only on the RUN->DONE edge.

## Timing
- Reset: the FSM returns to IDLE immediately.
  - Outputs: busy=0, done=0, Sum=0, Cout=0.
  - Internal registers: shA, shB, shS, carry and cnt are all cleared.
- Reset mid-operation discards the operation with no done pulse. Operation resumes on the first clk edge after rst deasserts.
- start accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH.
  - Sum, Cout and done update at edge k+WIDTH.
  - done is high for exactly the cycle after edge k+WIDTH.
  - The FSM is back in IDLE after edge k+WIDTH+1.
- Throughput: one result per WIDTH+2 cycles with start held high.
- busy and done are never high at the same time.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is captured together with the operands.
  - sub=1: shB loads ~B, carry loads 1, and Cin is ignored. Result = A-B mod 2^WIDTH; Cout=1 means no borrow.
  - sub=0: behaviour is identical to the build without the macro.
- SERIAL_ADDER_SUB_EN not defined: the sub port and the inversion logic are absent, and the block performs addition only.

## Structure
- Shared package serial_adder_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - the default WIDTH constant.
- Sub-module full_adder_bit:
  - purely combinational one-bit full adder;
  - ports A, B, Cin, Sum, Cout;
  - instantiated once;
  - Sum = A^B^Cin, Cout = majority(A,B,Cin).
- All sequencing lives in serial_adder.

## Test plan
- Reset check: assert rst, then release. Required: busy=0, done=0, Sum=8'h00, Cout=0, and busy stays 0 with start=0.
- Basic add: A=8'h0F, B=8'h01, Cin=0, one-cycle start. Required:
  - busy high for 8 cycles;
  - done pulses once;
  - Sum=8'h10, Cout=0.
- Wrap-around add: A=8'hFF, B=8'h01, Cin=0. Required: Sum=8'h00, Cout=1.
- Carry-in add: A=8'hFF, B=8'hFF, Cin=1. Required: Sum=8'hFF, Cout=1.
- Start while busy is ignored:
  - Launch A=8'h12, B=8'h34, Cin=0.
  - During RUN, pulse start with A=8'hAA, B=8'h55.
  - Required: Sum=8'h46, Cout=0, and only one done pulse.
- Reset mid-operation:
  - Stimulus: launch A=8'h80, B=8'h80; assert rst at cycle 4 of RUN.
  - Required: busy=0, Sum=0 and no done pulse.
  - Then launch A=8'h03, B=8'h04, Cin=0. Required: Sum=8'h07.
- With SERIAL_ADDER_SUB_EN defined:
  - A=8'h05, B=8'h07, sub=1. Required: Sum=8'hFE, Cout=0.
  - A=8'h07, B=8'h05, sub=1. Required: Sum=8'h02, Cout=1.
